// File: rtl/fifo_pkg.sv
// fifo_pkg: shared state type and constants for the FIFO read-side controller
package fifo_pkg;
    localparam int FIFO_BITS = 12;
    localparam int DRAIN_BUF_DEPTH = 2;
    typedef enum logic [1:0] {IDLE, RUN, FLUSH} drain_state_t;
endpackage

// File: rtl/drain_skid_buf.sv
// drain_skid_buf: 2-entry FIFO buffer absorbing the one-cycle FIFO read latency
module drain_skid_buf
    import fifo_pkg::*;
#(
    parameter int BITS = FIFO_BITS
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  logic            wr_en,
    input  logic [BITS-1:0] wr_data,
    input  logic            rd_en,
    output logic [BITS-1:0] rd_data,
    output logic [1:0]      occ
);
    logic [BITS-1:0] mem_q [2];
    logic [BITS-1:0] mem_d [2];
    logic            head_q, head_d, tail_q, tail_d;
    logic [1:0]      occ_q, occ_d;
    logic [BITS-1:0] out_q, out_d;

    // write at tail, pop at head; the head word is re-registered so it holds once empty
    always_comb begin
        mem_d = mem_q;
        if (wr_en) mem_d[tail_q] = wr_data;
        head_d = clr ? 1'b0 : head_q ^ rd_en;
        tail_d = clr ? 1'b0 : tail_q ^ wr_en;
        occ_d  = clr ? 2'd0 : occ_q + {1'b0, wr_en} - {1'b0, rd_en};
        out_d  = (occ_d != 2'd0) ? mem_d[head_d] : out_q;
    end

    // storage and pointer registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q  <= '{default: '0};
            head_q <= 1'b0;
            tail_q <= 1'b0;
            occ_q  <= 2'd0;
            out_q  <= '0;
        end else begin
            mem_q  <= mem_d;
            head_q <= head_d;
            tail_q <= tail_d;
            occ_q  <= occ_d;
            out_q  <= out_d;
        end
    end

    assign rd_data = out_q;
    assign occ     = occ_q;

    a_no_overflow:  assert property (@(posedge clk) disable iff (rst) !(wr_en && !rd_en && occ_q == 2'd2));
    a_no_underflow: assert property (@(posedge clk) disable iff (rst) !(rd_en && occ_q == 2'd0));
endmodule

// File: rtl/fifo_drain.sv
// fifo_drain: FIFO read-side controller with flush and sticky overflow flag;
// FIFO_DRAIN_STATS_EN adds word_count/stall_count statistics outputs
module fifo_drain
    import fifo_pkg::*;
#(
    parameter int BITS      = FIFO_BITS,
    parameter int BUF_DEPTH = DRAIN_BUF_DEPTH
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            enable,
    input  logic            flush,
    output logic            fifo_read,
    input  logic [BITS-1:0] fifo_data,
    input  logic            fifo_ready,
    input  logic            fifo_overflow,
    output logic [BITS-1:0] out_data,
    output logic            out_valid,
    input  logic            out_ready,
`ifdef FIFO_DRAIN_STATS_EN
    output logic [31:0]     word_count,
    output logic [31:0]     stall_count,
`endif
    output logic            err_overflow
);
    if (BUF_DEPTH != DRAIN_BUF_DEPTH) begin : g_depth_check
        $error("fifo_drain: BUF_DEPTH must be 2");
    end

    drain_state_t state_q, state_d;
    logic         inflight_q, inflight_d;
    logic         err_q, err_d;
    logic [1:0]   occ;
    logic [2:0]   credit;
    logic         pop;

    assign out_valid    = occ != 2'd0;
    assign pop          = out_valid & out_ready;
    assign err_overflow = err_q;

    drain_skid_buf #(.BITS(BITS)) u_buf (
        .clk     (clk),
        .rst     (rst),
        .clr     (flush),
        .wr_en   (inflight_q & ~flush),
        .wr_data (fifo_data),
        .rd_en   (pop),
        .rd_data (out_data),
        .occ     (occ)
    );

    // credit check keeps buffered plus in-flight words within the two buffer slots
    always_comb begin
        credit     = {1'b0, occ} + {2'b0, inflight_q} - {2'b0, pop};
        fifo_read  = (state_q == RUN) && fifo_ready && !flush && credit < 3'd2;
        state_d    = flush ? FLUSH : (state_q != FLUSH && enable) ? RUN : IDLE;
        inflight_d = fifo_read;
        err_d      = err_q | fifo_overflow;
    end

    // FSM, in-flight marker and sticky error
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            inflight_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            inflight_q <= inflight_d;
            err_q      <= err_d;
        end
    end

`ifdef FIFO_DRAIN_STATS_EN
    logic [31:0] word_count_q, word_count_d, stall_count_q, stall_count_d;

    // delivered words wrap, stall cycles saturate
    always_comb begin
        word_count_d  = flush ? 32'd0 : word_count_q + {31'd0, pop};
        stall_count_d = (out_valid && !out_ready && stall_count_q != '1) ? stall_count_q + 32'd1 : stall_count_q;
    end

    // statistics registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_count_q  <= 32'd0;
            stall_count_q <= 32'd0;
        end else begin
            word_count_q  <= word_count_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign word_count  = word_count_q;
    assign stall_count = stall_count_q;
`endif
endmodule

// File: tb/tb_fifo_drain.sv
// tb_fifo_drain: directed checks of fifo_drain against a behavioural FIFO model
module tb_fifo_drain;
    logic        clk = 1'b0;
    logic        rst = 1'b1, enable = 1'b0, flush = 1'b0, fifo_overflow = 1'b0, out_ready = 1'b0;
    logic        fifo_read, fifo_ready, out_valid, err_overflow;
    logic [11:0] fifo_data = '0;
    logic [11:0] out_data;
`ifdef FIFO_DRAIN_STATS_EN
    logic [31:0] word_count, stall_count;
`endif
    logic [11:0] fmem [256];
    logic [7:0]  rd_ptr = '0, wr_ptr = '0;
    logic        rd_req = 1'b0;
    logic [11:0] got [$];
    int          rd_count = 0, max_occ = 0;
    int          n_total = 0, n_pass = 0;

    fifo_drain #(.BITS(12), .BUF_DEPTH(2)) u_dut (
        .clk           (clk),
        .rst           (rst),
        .enable        (enable),
        .flush         (flush),
        .fifo_read     (fifo_read),
        .fifo_data     (fifo_data),
        .fifo_ready    (fifo_ready),
        .fifo_overflow (fifo_overflow),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
`ifdef FIFO_DRAIN_STATS_EN
        .word_count    (word_count),
        .stall_count   (stall_count),
`endif
        .err_overflow  (err_overflow)
    );

    always #5 clk = ~clk;

    assign fifo_ready = rd_ptr != wr_ptr;

    always @(posedge clk) begin
        if (rd_req) begin
            fifo_data <= fmem[rd_ptr];
            rd_ptr    <= rd_ptr + 8'd1;
        end
    end

    always @(negedge clk) begin
        rd_req = fifo_read;
        if (fifo_read) rd_count++;
        if (out_valid && out_ready) got.push_back(out_data);
        if (int'(u_dut.u_buf.occ_q) > max_occ) max_occ = int'(u_dut.u_buf.occ_q);
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic load(input int n);
        for (int i = 0; i < n; i++) fmem[8'(int'(rd_ptr) + i)] = 12'h0e0 + 12'(i);
        wr_ptr = 8'(int'(rd_ptr) + n);
    endtask

    task automatic do_reset();
        rst = 1'b1; enable = 1'b0; flush = 1'b0; out_ready = 1'b0; fifo_overflow = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        got.delete(); rd_count = 0; max_occ = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b1; out_ready = 1'b1;
        load(3);
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_total++; if (fifo_read !== 1'b0) $display("FAIL reset_fifo_read: got %b want 0", fifo_read); else n_pass++;
        n_total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else n_pass++;
        n_total++; if (out_data !== 12'h000) $display("FAIL reset_out_data: got %h want 000", out_data); else n_pass++;
        n_total++; if (err_overflow !== 1'b0) $display("FAIL reset_err: got %b want 0", err_overflow); else n_pass++;
        enable = 1'b0;
    endtask

    task automatic test_stream();
        int first_rd = -1, last_rd = -1, first_v = -1, bad = 0;
        do_reset();
        load(5);
        out_ready = 1'b1; enable = 1'b1;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (fifo_read) begin
                if (first_rd < 0) first_rd = c;
                last_rd = c;
            end
            if (out_valid && first_v < 0) first_v = c;
        end
        for (int i = 0; i < got.size(); i++) if (got[i] !== 12'h0e0 + 12'(i)) bad++;
        n_total++; if (rd_count != 5) $display("FAIL stream_reads: got %0d want 5", rd_count); else n_pass++;
        n_total++; if (last_rd - first_rd != 4) $display("FAIL stream_read_span: got %0d want 4", last_rd - first_rd); else n_pass++;
        n_total++; if (first_v != first_rd + 2) $display("FAIL stream_latency: got cycle %0d want %0d", first_v, first_rd + 2); else n_pass++;
        n_total++; if (got.size() != 5 || bad != 0) $display("FAIL stream_order: got %0d words %0d wrong want 5 words 0", got.size(), bad); else n_pass++;
    endtask

    task automatic test_backpressure();
        int bad = 0;
        do_reset();
        load(8);
        enable = 1'b1;
        repeat (10) @(negedge clk);
        n_total++; if (rd_count != 2) $display("FAIL bp_reads: got %0d want 2", rd_count); else n_pass++;
        n_total++; if (out_valid !== 1'b1) $display("FAIL bp_valid: got %b want 1", out_valid); else n_pass++;
        n_total++; if (out_data !== 12'h0e0) $display("FAIL bp_head: got %h want 0e0", out_data); else n_pass++;
        @(posedge clk); #1 out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < got.size(); i++) if (got[i] !== 12'h0e0 + 12'(i)) bad++;
        n_total++; if (got.size() != 3 || bad != 0) $display("FAIL bp_release: got %0d words %0d wrong want 3 words 0", got.size(), bad); else n_pass++;
        n_total++; if (out_data !== 12'h0e3) $display("FAIL bp_next_head: got %h want 0e3", out_data); else n_pass++;
        n_total++; if (rd_count != 5) $display("FAIL bp_total_reads: got %0d want 5", rd_count); else n_pass++;
    endtask

    task automatic test_toggle();
        int bad = 0;
        do_reset();
        load(8);
        enable = 1'b1;
        repeat (6) @(posedge clk);
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1 out_ready = ~out_ready;
        end
        out_ready = 1'b1;
        repeat (4) @(negedge clk);
        for (int i = 0; i < got.size(); i++) if (got[i] !== 12'h0e0 + 12'(i)) bad++;
        n_total++; if (max_occ != 2) $display("FAIL toggle_max_occ: got %0d want 2", max_occ); else n_pass++;
        n_total++; if (got.size() != 8 || bad != 0) $display("FAIL toggle_order: got %0d words %0d wrong want 8 words 0", got.size(), bad); else n_pass++;
    endtask

    task automatic test_flush();
        int n = 0;
        do_reset();
        load(8);
        enable = 1'b1;
        while (rd_count < 2 && n < 20) begin
            @(negedge clk);
            n++;
        end
        n_total++; if (rd_count != 2) $display("FAIL flush_setup_reads: got %0d want 2", rd_count); else n_pass++;
        @(posedge clk); #1 flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        @(negedge clk);
        n_total++; if (out_valid !== 1'b0) $display("FAIL flush_valid: got %b want 0", out_valid); else n_pass++;
        out_ready = 1'b1;
        n = 0;
        while (got.size() < 2 && n < 30) begin
            @(negedge clk);
            n++;
        end
        n_total++;
        if (got.size() < 2) $display("FAIL flush_resume: got %0d words want 2", got.size());
        else if (got[0] !== 12'h0e2 || got[1] !== 12'h0e3) $display("FAIL flush_resume: got %h %h want 0e2 0e3", got[0], got[1]);
        else n_pass++;
    endtask

    task automatic test_overflow();
        do_reset();
        @(posedge clk); #1 fifo_overflow = 1'b1;
        @(negedge clk);
        n_total++; if (err_overflow !== 1'b0) $display("FAIL ovf_early: got %b want 0", err_overflow); else n_pass++;
        @(posedge clk); #1 fifo_overflow = 1'b0;
        @(negedge clk);
        n_total++; if (err_overflow !== 1'b1) $display("FAIL ovf_set: got %b want 1", err_overflow); else n_pass++;
        @(posedge clk); #1 flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        repeat (2) @(negedge clk);
        n_total++; if (err_overflow !== 1'b1) $display("FAIL ovf_sticky: got %b want 1", err_overflow); else n_pass++;
        #2 rst = 1'b1;
        #1;
        n_total++; if (err_overflow !== 1'b0) $display("FAIL ovf_rst: got %b want 0", err_overflow); else n_pass++;
        @(posedge clk); #1 rst = 1'b0;
    endtask

`ifdef FIFO_DRAIN_STATS_EN
    task automatic test_stats();
        int n = 0;
        do_reset();
        load(5);
        enable = 1'b1;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
        n = 0;
        while (got.size() < 5 && n < 30) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        n_total++; if (word_count !== 32'd5) $display("FAIL stats_words: got %0d want 5", word_count); else n_pass++;
        n_total++; if (stall_count !== 32'd3) $display("FAIL stats_stalls: got %0d want 3", stall_count); else n_pass++;
        load(4);
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_total++; if (word_count !== 32'd0) $display("FAIL stats_rst_words: got %0d want 0", word_count); else n_pass++;
        n_total++; if (stall_count !== 32'd0) $display("FAIL stats_rst_stalls: got %0d want 0", stall_count); else n_pass++;
        @(posedge clk); #1 enable = 1'b0; rst = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_toggle();
        test_flush();
        test_overflow();
`ifdef FIFO_DRAIN_STATS_EN
        test_stats();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
